dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue.sv | 150 +++++++++++++++
 tb/tb_dispatch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// Dispatch queue: in-order circular buffer between rename and the RS.
// Optional same-cycle bypass when empty: define DQ_BYPASS_EN.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   pipe_flush          squash everything queued and this cycle's input
//   in_pkt / in_ready   renamed lanes in, each gated by packet_valid
//   dispatch_pkt        oldest entries offered to the RS, lane 0 oldest
//   dispatch_pkt_ready  RS acceptance mask (thermometer code)
//   dq_cnt / dq_empty   occupancy
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif

package dq_pkg;
    typedef struct packed {
        logic        packet_valid;
        logic [15:0] tag;
        logic [31:0] pc;
    } DISPATCH_RS_PACKET;
endpackage

module dispatch_queue
    import dq_pkg::*;
#(
    parameter int DQ_DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pipe_flush,
    input  DISPATCH_RS_PACKET in_pkt [0:`MACHINE_WIDTH-1],
    output logic in_ready,
    output DISPATCH_RS_PACKET dispatch_pkt [0:`MACHINE_WIDTH-1],
    input  logic [`MACHINE_WIDTH-1:0] dispatch_pkt_ready,
    output logic [$clog2(DQ_DEPTH):0] dq_cnt,
    output logic dq_empty
);
    localparam int W  = `MACHINE_WIDTH;
    localparam int PW = $clog2(DQ_DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    ptr_t head;
    ptr_t tail;
    DISPATCH_RS_PACKET mem [DQ_DEPTH];

    DISPATCH_RS_PACKET comp   [W];
    DISPATCH_RS_PACKET wr_pkt [W];
    cnt_t n_in;
    cnt_t n_fire;
    cnt_t n_wr;
    cnt_t n_pop;
    logic [W-1:0] fire;
    logic accept;

    assign in_ready = (cnt_t'(DQ_DEPTH) - dq_cnt) >= cnt_t'(W);
    assign dq_empty = (dq_cnt == '0);
    assign accept   = in_ready & ~pipe_flush;

    // Squeeze valid lanes down to slots 0..n_in-1, keeping lane order.
    always_comb begin
        int idx;
        idx = 0;
        for (int i = 0; i < W; i++) comp[i] = '0;
        for (int i = 0; i < W; i++) begin
            if (accept && in_pkt[i].packet_valid) begin
                comp[idx] = in_pkt[i];
                idx = idx + 1;
            end
        end
        n_in = cnt_t'(idx);
    end

`ifdef DQ_BYPASS_EN
    logic bypass;
    assign bypass = accept && (dq_cnt == '0);
`endif

    always_comb begin
        for (int k = 0; k < W; k++) begin
            dispatch_pkt[k] = mem[head + ptr_t'(k)];
            dispatch_pkt[k].packet_valid = (cnt_t'(k) < dq_cnt);
`ifdef DQ_BYPASS_EN
            if (bypass) dispatch_pkt[k] = comp[k];
`endif
            if (pipe_flush || !rst_n)
                dispatch_pkt[k].packet_valid = 1'b0;
        end
    end

    // A lane fires only if every older lane fires too.
    always_comb begin
        fire[0] = dispatch_pkt[0].packet_valid
                & dispatch_pkt_ready[0];
        for (int k = 1; k < W; k++)
            fire[k] = fire[k-1]
                    & dispatch_pkt[k].packet_valid
                    & dispatch_pkt_ready[k];
        n_fire = '0;
        for (int k = 0; k < W; k++)
            if (fire[k]) n_fire = n_fire + cnt_t'(1);
    end

    // In bypass, fired lanes leave straight from the input;
    // only the unfired tail of the compacted group is stored.
    always_comb begin
        n_pop = n_fire;
        n_wr  = n_in;
        for (int j = 0; j < W; j++) wr_pkt[j] = comp[j];
`ifdef DQ_BYPASS_EN
        if (bypass) begin
            n_pop = '0;
            n_wr  = n_in - n_fire;
            for (int j = 0; j < W; j++) begin
                wr_pkt[j] = '0;
                for (int s = 0; s < W; s++)
                    if (cnt_t'(s) == cnt_t'(j) + n_fire)
                        wr_pkt[j] = comp[s];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            dq_cnt <= '0;
        end else if (pipe_flush) begin
            head   <= '0;
            tail   <= '0;
            dq_cnt <= '0;
        end else begin
            head   <= head + ptr_t'(n_pop);
            tail   <= tail + ptr_t'(n_wr);
            dq_cnt <= dq_cnt + n_wr - n_pop;
        end
    end

    // Payload is never reset; occupancy masks stale entries.
    always_ff @(posedge clk) begin
        if (!pipe_flush) begin
            for (int j = 0; j < W; j++)
                if (cnt_t'(j) < n_wr)
                    mem[tail + ptr_t'(j)] <= wr_pkt[j];
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: a packet queue model
// predicts occupancy, readiness and every dispatched payload.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif

module tb_dispatch_queue;
    import dq_pkg::*;

    localparam int W     = `MACHINE_WIDTH;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;
    logic pipe_flush;
    DISPATCH_RS_PACKET in_pkt [0:W-1];
    logic in_ready;
    DISPATCH_RS_PACKET dispatch_pkt [0:W-1];
    logic [W-1:0] dispatch_pkt_ready;
    logic [$clog2(DEPTH):0] dq_cnt;
    logic dq_empty;

    dispatch_queue #(.DQ_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pipe_flush(pipe_flush),
        .in_pkt(in_pkt),
        .in_ready(in_ready),
        .dispatch_pkt(dispatch_pkt),
        .dispatch_pkt_ready(dispatch_pkt_ready),
        .dq_cnt(dq_cnt),
        .dq_empty(dq_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int seq    = 0;

    DISPATCH_RS_PACKET model [$];
    DISPATCH_RS_PACKET comp  [$];

    task automatic check(input string name,
                         input longint act,
                         input longint exp);
        total++;
        if (act != exp)
            $display("FAIL %s: got %0d, want %0d",
                     name, act, exp);
        else
            passed++;
    endtask

    function automatic longint pay(DISPATCH_RS_PACKET p);
        return longint'({p.tag, p.pc});
    endfunction

    // Monitor: compares, then advances the model to the next edge.
    always @(negedge clk) begin
        bit exp_rdy, byp, ev, go;
        int nf;
        if (!rst_n) begin
            model.delete();
            check("rst_cnt", longint'(dq_cnt), 0);
            check("rst_empty", longint'(dq_empty), 1);
            check("rst_ready", longint'(in_ready), 1);
            for (int k = 0; k < W; k++)
                check("rst_valid",
                      longint'(dispatch_pkt[k].packet_valid), 0);
        end else begin
            exp_rdy = (DEPTH - model.size()) >= W;
            check("in_ready", longint'(in_ready),
                  longint'(exp_rdy));
            check("dq_cnt", longint'(dq_cnt),
                  longint'(model.size()));
            check("dq_empty", longint'(dq_empty),
                  longint'(model.size() == 0));
            comp.delete();
            if (exp_rdy && !pipe_flush)
                for (int i = 0; i < W; i++)
                    if (in_pkt[i].packet_valid)
                        comp.push_back(in_pkt[i]);
            byp = 1'b0;
`ifdef DQ_BYPASS_EN
            byp = (model.size() == 0) && (comp.size() > 0);
`endif
            nf = 0;
            go = 1'b1;
            for (int k = 0; k < W; k++) begin
                if (pipe_flush) ev = 1'b0;
                else if (byp) ev = k < comp.size();
                else ev = k < model.size();
                check("out_valid",
                      longint'(dispatch_pkt[k].packet_valid),
                      longint'(ev));
                if (ev && dispatch_pkt[k].packet_valid)
                    check("out_payload", pay(dispatch_pkt[k]),
                          byp ? pay(comp[k]) : pay(model[k]));
                if (go && ev && dispatch_pkt_ready[k]) nf++;
                else go = 1'b0;
            end
            if (pipe_flush) begin
                model.delete();
            end else if (byp) begin
                for (int i = nf; i < comp.size(); i++)
                    model.push_back(comp[i]);
            end else begin
                repeat (nf) void'(model.pop_front());
                foreach (comp[i]) model.push_back(comp[i]);
            end
        end
    end

    task automatic set_idle();
        for (int i = 0; i < W; i++) in_pkt[i] = '0;
        dispatch_pkt_ready = '0;
        pipe_flush = 1'b0;
    endtask

    task automatic step(input logic [W-1:0] vm,
                        input logic [W-1:0] rdy,
                        input logic fl);
        for (int i = 0; i < W; i++) begin
            in_pkt[i].packet_valid = vm[i];
            in_pkt[i].tag = vm[i] ? 16'(seq) : 16'hdead;
            in_pkt[i].pc  = $urandom;
            if (vm[i]) seq++;
        end
        dispatch_pkt_ready = rdy;
        pipe_flush = fl;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] therm [5];

    initial begin
        therm[0] = 4'b0000;
        therm[1] = 4'b0001;
        therm[2] = 4'b0011;
        therm[3] = 4'b0111;
        therm[4] = 4'b1111;
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full, then drain 12, 8, 4, 0.
        repeat (4) step(4'b1111, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b0);
        repeat (4) step(4'b0000, 4'b1111, 1'b0);

        // Sparse lanes 1 and 3 compact to slots 0 and 1.
        step(4'b1010, 4'b0000, 1'b0);
        step(4'b0000, 4'b0011, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);

        // Enqueue 3, dequeue 1 until back-pressure.
        repeat (8) step(4'b0111, 4'b0001, 1'b0);
        repeat (5) step(4'b0000, 4'b1111, 1'b0);

        // Flush with 4 inputs at occupancy 7.
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b0111, 4'b0000, 1'b0);
        step(4'b1111, 4'b1111, 1'b1);
        repeat (2) step(4'b0000, 4'b1111, 1'b0);

        // Move head to 14, then fire 14,15,0,1.
        repeat (3) step(4'b1111, 4'b0000, 1'b0);
        step(4'b0011, 4'b0000, 1'b0);
        repeat (4) step(4'b0000, 4'b1111, 1'b0);
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b0000, 4'b1111, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);

        // Two inputs into an empty queue with full readiness.
        step(4'b0011, 4'b1111, 1'b0);
        step(4'b0000, 4'b1111, 1'b0);

        // Reset mid-traffic at occupancy 9.
        repeat (2) step(4'b1111, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cnt", longint'(dq_cnt), 0);
        check("async_empty", longint'(dq_empty), 1);
        check("async_ready", longint'(in_ready), 1);
        for (int k = 0; k < W; k++)
            check("async_valid",
                  longint'(dispatch_pkt[k].packet_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);

        // Random traffic.
        for (int c = 0; c < 600; c++)
            step(4'($urandom), therm[$urandom_range(0, 4)],
                 ($urandom_range(0, 99) < 3));

        repeat (6) step(4'b0000, 4'b1111, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
